// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the IF/MEM to byte-wide RAM/IO bus arbiter.
package mem_ctrl_pkg;

  localparam logic [1:0]  LEN_BYTE  = 2'b00;
  localparam logic [1:0]  LEN_HALF  = 2'b01;
  localparam logic [31:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_IO_WAIT
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_t;

  // Index of the final byte of an access (N-1); code 11 is treated as a word.
  function automatic logic [1:0] last_byte(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 2'd0;
      LEN_HALF: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF fetches and MEM loads/stores onto an 8-bit RAM/IO bus,
// serialising each access into byte transfers and assembling reads little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_enable,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_clear,
  output logic              if_finished,
  output logic [31:0]       if_inst,
  output logic              if_busy,
  input  logic              mem_enable,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic              mem_finished,
  output logic [31:0]       mem_rdata,
  output logic              mem_busy,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  input  logic              io_buffer_full
);

  state_t            state, state_n;
  owner_t            owner, owner_n;
  logic [1:0]        cnt, cnt_n, last, last_n, cnt_inc;
  logic [ADDR_W-1:0] ram_a_n;
  logic              wr_q, wr_n;
  logic [7:0]        dout_n;
  logic [31:0]       wdata, wdata_n, data, data_n, merged;
  logic [31:0]       if_inst_n, mem_rdata_n;
  logic              if_fin_n, mem_fin_n;

  assign cnt_inc = cnt + 2'd1;
  // Data word including the byte arriving on ram_din this cycle.
  assign merged  = data | ({24'd0, ram_din} << {cnt, 3'b000});

  // A stall suppresses the write strobe; the frozen state re-issues the byte later.
  assign ram_wr   = wr_q & rdy;
  assign if_busy  = (state != S_IDLE) && (owner == OWN_IF);
  assign mem_busy = ((state != S_IDLE) && (owner == OWN_MEM)) || mem_enable;

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    cnt_n       = cnt;
    last_n      = last;
    ram_a_n     = ram_a;
    wr_n        = 1'b0;
    dout_n      = ram_dout;
    wdata_n     = wdata;
    data_n      = data;
    if_inst_n   = if_inst;
    mem_rdata_n = mem_rdata;
    if_fin_n    = 1'b0;
    mem_fin_n   = 1'b0;

    case (state)
      S_IDLE: begin
        if (mem_enable) begin
          owner_n = OWN_MEM;
          cnt_n   = '0;
          last_n  = last_byte(mem_len);
          ram_a_n = mem_addr;
          data_n  = '0;
          if (mem_wr) begin
            wdata_n = mem_wdata;
            if ((mem_addr[17:16] == IO_HI) && io_buffer_full) begin
              state_n = S_IO_WAIT;
            end else begin
              state_n = S_WRITE;
              wr_n    = 1'b1;
              dout_n  = mem_wdata[7:0];
            end
          end else begin
            state_n = S_READ;
          end
        end else if (if_enable && !if_clear) begin
          owner_n = OWN_IF;
          cnt_n   = '0;
          last_n  = 2'd3;
          ram_a_n = if_addr;
          data_n  = '0;
          state_n = S_READ;
        end
      end

      S_READ: begin
        if ((owner == OWN_IF) && if_clear) begin
          state_n = S_IDLE;
        end else begin
          data_n = merged;
          if (cnt == last) begin
            state_n = S_IDLE;
            if (owner == OWN_IF) begin
              if_fin_n  = 1'b1;
              if_inst_n = merged;
            end else begin
              mem_fin_n   = 1'b1;
              mem_rdata_n = merged;
            end
          end else begin
            cnt_n   = cnt_inc;
            ram_a_n = ram_a + ADDR_W'(1);
          end
        end
      end

      S_WRITE: begin
        if (cnt == last) begin
          state_n   = S_IDLE;
          mem_fin_n = 1'b1;
        end else begin
          cnt_n   = cnt_inc;
          ram_a_n = ram_a + ADDR_W'(1);
          wr_n    = 1'b1;
          dout_n  = wdata[{cnt_inc, 3'b000} +: 8];
        end
      end

      S_IO_WAIT: begin
        // ram_a already holds the start address; release behaves as a fresh write start.
        if (!io_buffer_full) begin
          state_n = S_WRITE;
          wr_n    = 1'b1;
          dout_n  = wdata[7:0];
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      owner        <= OWN_IF;
      cnt          <= '0;
      last         <= '0;
      ram_a        <= '0;
      wr_q         <= 1'b0;
      ram_dout     <= '0;
      wdata        <= ZERO_WORD;
      data         <= ZERO_WORD;
      if_inst      <= ZERO_WORD;
      mem_rdata    <= ZERO_WORD;
      if_finished  <= 1'b0;
      mem_finished <= 1'b0;
    end else if (rdy) begin
      state        <= state_n;
      owner        <= owner_n;
      cnt          <= cnt_n;
      last         <= last_n;
      ram_a        <= ram_a_n;
      wr_q         <= wr_n;
      ram_dout     <= dout_n;
      wdata        <= wdata_n;
      data         <= data_n;
      if_inst      <= if_inst_n;
      mem_rdata    <= mem_rdata_n;
      if_finished  <= if_fin_n;
      mem_finished <= mem_fin_n;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed bus scenarios plus randomized
// fetch/load/store traffic checked against a byte-addressed memory model.
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, if_enable, if_clear, mem_enable, mem_wr, io_buffer_full;
  logic [31:0] if_addr, mem_addr, mem_wdata, if_inst, mem_rdata, ram_a;
  logic [1:0]  mem_len;
  logic        if_finished, if_busy, mem_finished, mem_busy, ram_wr;
  logic [7:0]  ram_din, ram_dout;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  ref_mem [logic [31:0]];
  logic [7:0]  phys    [logic [31:0]];
  logic [39:0] wr_log  [$];

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_enable(if_enable), .if_addr(if_addr), .if_clear(if_clear),
    .if_finished(if_finished), .if_inst(if_inst), .if_busy(if_busy),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_len(mem_len), .mem_wdata(mem_wdata), .mem_finished(mem_finished),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .io_buffer_full(io_buffer_full)
  );

  // Initial memory image: scenario bytes at fixed addresses, a hash elsewhere.
  function automatic logic [7:0] pat(input logic [31:0] a);
    case (a)
      32'h1000: return 8'h13;
      32'h1001: return 8'h05;
      32'h1002: return 8'h00;
      32'h1003: return 8'h00;
      32'h2003: return 8'hAB;
      32'h3000: return 8'h34;
      32'h3001: return 8'h12;
      default:  return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  function automatic logic [7:0] phys_rd(input logic [31:0] a);
    return phys.exists(a) ? phys[a] : pat(a);
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  // RAM: an address launched at a posedge is answered before the following posedge.
  always @(negedge clk) begin
    if (ram_wr) begin
      wr_log.push_back({ram_a, ram_dout});
      phys[ram_a] = ram_dout;
    end
    ram_din = phys_rd(ram_a);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input bit is_if, input bit wr, input logic [31:0] addr,
                          input logic [1:0] len, input logic [31:0] wdata);
    if (is_if) begin
      if_addr   = addr;
      if_enable = 1'b1;
    end else begin
      mem_addr   = addr;
      mem_wr     = wr;
      mem_len    = len;
      mem_wdata  = wdata;
      mem_enable = 1'b1;
    end
    @(posedge clk); #1;
    if_enable  = 1'b0;
    mem_enable = 1'b0;
    chk("accept_busy", 32'(is_if ? if_busy : mem_busy), 32'd1);
  endtask

  // Counts rdy-high edges until the requester's finished pulse appears.
  task automatic wait_fin(input bit is_if, input bit stall, output int good, output bit seen);
    good = 0;
    seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk);
      if (rdy) good++;
      #1;
      seen = is_if ? if_finished : mem_finished;
    end
    rdy = 1'b1;
  endtask

  task automatic check_writes(input string tag, input logic [31:0] addr, input int n,
                              input logic [31:0] wdata);
    logic [39:0] e;
    chk({tag, "_wcount"}, 32'(wr_log.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
      if (i < wr_log.size()) begin
        e = wr_log[i];
        chk({tag, "_waddr"}, e[39:8], addr + 32'(i));
        chk({tag, "_wbyte"}, 32'(e[7:0]), 32'(wdata[8*i +: 8]));
      end
    end
  endtask

  task automatic do_op(input bit is_if, input bit wr, input logic [31:0] addr,
                       input logic [1:0] len, input logic [31:0] wdata,
                       input bit stall, input string tag);
    int          n, good;
    bit          seen;
    logic [31:0] exp;
    n   = is_if ? 4 : nbytes(len);
    exp = '0;
    if (!wr) for (int i = 0; i < n; i++) exp[8*i +: 8] = ref_rd(addr + 32'(i));
    wr_log.delete();
    start_op(is_if, wr, addr, len, wdata);
    wait_fin(is_if, stall, good, seen);
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(good), 32'(n));
    if (wr) check_writes(tag, addr, n, wdata);
    else    chk({tag, "_data"}, is_if ? if_inst : mem_rdata, exp);
    @(posedge clk); #1;
    chk({tag, "_pulse_width"}, 32'(is_if ? if_finished : mem_finished), 32'd0);
  endtask

  initial begin
    int          k, good;
    bit          seen, any;
    bit          is_if, wr;
    logic [31:0] addr, wdata;
    logic [1:0]  len;

    rst = 1'b0; rdy = 1'b1; if_enable = 1'b0; if_clear = 1'b0; if_addr = '0;
    mem_enable = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_len = '0; mem_wdata = '0;
    io_buffer_full = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_if_finished", 32'(if_finished), 32'd0);
    chk("rst_mem_finished", 32'(mem_finished), 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_dout", 32'(ram_dout), 32'd0);
    chk("rst_busy", {30'd0, if_busy, mem_busy}, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    do_op(1'b1, 1'b0, 32'h1000, 2'b10, '0, 1'b0, "fetch");
    chk("fetch_inst_value", if_inst, 32'h0000_0513);

    // Both requesters at once: the byte load goes first, the fetch starts at the next IDLE edge.
    if_addr = 32'h1000; if_enable = 1'b1;
    mem_addr = 32'h2003; mem_wr = 1'b0; mem_len = 2'b00; mem_enable = 1'b1;
    @(posedge clk); #1;
    mem_enable = 1'b0;
    chk("arb_mem_owner", {30'd0, if_busy, mem_busy}, 32'd1);
    @(posedge clk); #1;
    chk("arb_mem_finished", 32'(mem_finished), 32'd1);
    chk("arb_mem_rdata", mem_rdata, 32'h0000_00AB);
    @(posedge clk); #1;
    chk("arb_if_accept", 32'(if_busy), 32'd1);
    if_enable = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(posedge clk); #1;
      k++;
      seen = if_finished;
    end
    chk("arb_if_latency", 32'(k), 32'd4);
    chk("arb_if_inst", if_inst, 32'h0000_0513);
    @(posedge clk); #1;

    do_op(1'b0, 1'b1, 32'h40, 2'b10, 32'hDEAD_BEEF, 1'b0, "st_word");
    chk("st_word_b0", 32'(phys_rd(32'h40)), 32'h0000_00EF);
    chk("st_word_b3", 32'(phys_rd(32'h43)), 32'h0000_00DE);

    // IO store held off by a full buffer for five cycles.
    wr_log.delete();
    io_buffer_full = 1'b1;
    start_op(1'b0, 1'b1, 32'h0003_0000, 2'b00, 32'h0000_0077);
    any = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (ram_wr || mem_finished) any = 1'b1;
    end
    chk("io_wait_quiet", 32'(any), 32'd0);
    io_buffer_full = 1'b0;
    wait_fin(1'b0, 1'b0, good, seen);
    chk("io_seen", 32'(seen), 32'd1);
    chk("io_latency", 32'(good), 32'd2);
    check_writes("io", 32'h0003_0000, 1, 32'h0000_0077);
    @(posedge clk); #1;

    // Fetch aborted by if_clear while byte 2 is on the bus.
    start_op(1'b1, 1'b0, 32'h500, 2'b10, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("clr_ram_a_before", ram_a, 32'h502);
    if_clear = 1'b1;
    @(posedge clk); #1;
    if_clear = 1'b0;
    chk("clr_idle", 32'(if_busy), 32'd0);
    chk("clr_ram_a_after", ram_a, 32'h502);
    any = if_finished;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (if_finished) any = 1'b1;
    end
    chk("clr_no_finish", 32'(any), 32'd0);
    do_op(1'b1, 1'b0, 32'h600, 2'b10, '0, 1'b0, "clr_refetch");

    // Half load stalled by rdy=0 for three cycles after byte 0.
    start_op(1'b0, 1'b0, 32'h3000, 2'b01, '0);
    @(posedge clk); #1;
    rdy = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("stall_ld_hold", {ram_a[30:0], mem_finished}, {31'h3001, 1'b0});
    rdy = 1'b1;
    @(posedge clk); #1;
    chk("stall_ld_finished", 32'(mem_finished), 32'd1);
    chk("stall_ld_data", mem_rdata, 32'h0000_1234);
    @(posedge clk); #1;

    // Store stalled on its first byte: strobe suppressed, byte re-issued.
    wr_log.delete();
    start_op(1'b0, 1'b1, 32'h50, 2'b01, 32'h0000_C3A5);
    rdy = 1'b0;
    #1;
    chk("stall_st_wr_forced", 32'(ram_wr), 32'd0);
    @(posedge clk); #1;
    wait_fin(1'b0, 1'b0, good, seen);
    chk("stall_st_latency", 32'(good), 32'd2);
    check_writes("stall_st", 32'h50, 2, 32'h0000_C3A5);
    @(posedge clk); #1;

    // Reset pulse in the middle of a word load.
    start_op(1'b0, 1'b0, 32'h700, 2'b10, '0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midrst_ram_a", ram_a, 32'd0);
    chk("midrst_strobes", {29'd0, ram_wr, if_finished, mem_finished}, 32'd0);
    chk("midrst_busy", {30'd0, if_busy, mem_busy}, 32'd0);
    chk("midrst_data", mem_rdata | if_inst, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    any = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (mem_finished || mem_busy) any = 1'b1;
    end
    chk("midrst_no_finish", 32'(any), 32'd0);

    do_op(1'b0, 1'b0, 32'hFFFF_FFFE, 2'b10, '0, 1'b0, "wrap_ld");
    do_op(1'b0, 1'b1, 32'hFFFF_FFFF, 2'b01, 32'h0000_9A8B, 1'b0, "wrap_st");
    do_op(1'b1, 1'b0, 32'hFFFF_FFFD, 2'b10, '0, 1'b0, "wrap_fetch");

    for (int t = 0; t < 40; t++) begin
      k     = int'($urandom_range(0, 2));
      is_if = (k == 0);
      wr    = (k == 2);
      len   = 2'($urandom_range(0, 3));
      wdata = $urandom;
      if ($urandom_range(0, 7) == 0)      addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else if ($urandom_range(0, 1) == 1) addr = {24'h000012, 8'($urandom)};
      else                                addr = $urandom;
      do_op(is_if, wr, addr, len, wdata, 1'b1, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
